// File: rtl/mmio_port_pkg.sv
// Shared register map, STATUS field positions and FSM encoding for the
// MMIO port responder.
package mmio_port_pkg;

    localparam logic [3:0] OFF_PORTOUT = 4'h0;
    localparam logic [3:0] OFF_PORTIN  = 4'h4;
    localparam logic [3:0] OFF_EVENT   = 4'h8;
    localparam logic [3:0] OFF_STATUS  = 4'hC;

    localparam int ST_EMPTY   = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_CNT_LSB = 4;
    localparam int ST_CNT_MSB = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

endpackage

// File: rtl/event_fifo.sv
// Circular event FIFO with occupancy count; pointers wrap modulo DEPTH.
// A push while full is accepted only when a pop happens in the same cycle.
module event_fifo #(
    parameter int  DEPTH  = 4,
    parameter int  DATA_W = 8,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = PTR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] push_data,
    output logic [DATA_W-1:0] pop_data,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage needs no reset: entries are invisible until the count covers them.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/mmio_port_responder.sv
// Single-cycle-latency MMIO slave exposing an output port, a synchronized
// input port and a FIFO of input-port change events with sticky overflow.
module mmio_port_responder
    import mmio_port_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h1001_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ack,
    output logic [31:0] rdata,
    input  logic [7:0]  PortIn,
    output logic [31:0] PortOut,
    output logic        irq
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_t           state;
    state_t           state_nxt;
    logic             we_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic             hit;
    logic [3:0]       off;
    logic             wr_portout;
    logic             wr_status;
    logic             rd_event;
    logic             ev_push;
    logic             ev_pop;
    logic             ovf;
    logic             ovf_set;
    logic             ovf_clr;
    logic [7:0]       port_in_p0;
    logic [7:0]       port_in_p1;
    logic [7:0]       port_prev;
    logic [7:0]       fifo_head;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic [31:0]      status;
    logic [31:0]      rd_val;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && req) begin
            we_q    <= we;
            addr_q  <= addr;
            wdata_q <= wdata;
        end
    end

    // Ack is gated by reset so a reset landing in RESP aborts the response.
    always_comb begin
        state_nxt = state;
        ack       = 1'b0;
        case (state)
            IDLE: if (req) state_nxt = RESP;
            RESP: begin
                state_nxt = IDLE;
                ack       = !reset;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign hit        = (addr_q[31:4] == BASE_ADDR[31:4]) && (addr_q[1:0] == 2'b00);
    assign off        = addr_q[3:0];
    assign wr_portout = ack && we_q && hit && (off == OFF_PORTOUT);
    assign wr_status  = ack && we_q && hit && (off == OFF_STATUS);
    assign rd_event   = ack && !we_q && hit && (off == OFF_EVENT);

    // Two-flop synchronizer, then a change detector against the previous value.
    always_ff @(posedge clk) begin
        if (reset) begin
            port_in_p0 <= '0;
            port_in_p1 <= '0;
            port_prev  <= '0;
        end else begin
            port_in_p0 <= PortIn;
            port_in_p1 <= port_in_p0;
            port_prev  <= port_in_p1;
        end
    end

    assign ev_push = (port_in_p1 != port_prev);
    assign ev_pop  = rd_event && !fifo_empty;

    event_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (8)
    ) u_event_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (ev_push),
        .pop       (ev_pop),
        .push_data (port_in_p1),
        .pop_data  (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign ovf_set = ev_push && fifo_full && !ev_pop;
    assign ovf_clr = wr_status && wdata_q[ST_OVF];

    always_ff @(posedge clk) begin
        if (reset)        ovf <= 1'b0;
        else if (ovf_set) ovf <= 1'b1;
        else if (ovf_clr) ovf <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset)           PortOut <= '0;
        else if (wr_portout) PortOut <= wdata_q;
    end

    always_comb begin
        status                          = '0;
        status[ST_CNT_MSB:ST_CNT_LSB]   = 5'(fifo_count);
        status[ST_OVF]                  = ovf;
        status[ST_FULL]                 = fifo_full;
        status[ST_EMPTY]                = fifo_empty;
    end

    always_comb begin
        rd_val = '0;
        case (off)
            OFF_PORTOUT: rd_val = PortOut;
            OFF_PORTIN:  rd_val = {24'b0, port_in_p1};
            OFF_EVENT:   rd_val = fifo_empty ? 32'h0 : {24'b0, fifo_head};
            OFF_STATUS:  rd_val = status;
            default:     rd_val = '0;
        endcase
    end

    assign rdata = (ack && !we_q && hit) ? rd_val : 32'h0;
    assign irq   = !fifo_empty;

endmodule

// File: tb/tb_mmio_port_responder.sv
// Scoreboard bench for mmio_port_responder: driver pushes expected read data,
// a negedge monitor pops and compares on every ack.
module tb_mmio_port_responder;

    localparam logic [31:0] BASE  = 32'h1001_0000;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        ack;
    logic [31:0] rdata;
    logic [7:0]  PortIn = '0;
    logic [31:0] PortOut;
    logic        irq;

    always #5 clk = ~clk;

    mmio_port_responder #(
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .we      (we),
        .addr    (addr),
        .wdata   (wdata),
        .ack     (ack),
        .rdata   (rdata),
        .PortIn  (PortIn),
        .PortOut (PortOut),
        .irq     (irq)
    );

    int          pass_cnt = 0;
    int          tot_cnt  = 0;
    logic [31:0] exp_q[$];

    // Reference model: register contents as plain variables, FIFO as a queue.
    logic [31:0] m_portout = '0;
    logic [7:0]  m_fifo[$];
    bit          m_ovf = 1'b0;
    logic [7:0]  m_sync = '0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    endfunction

    function automatic bit in_window(input logic [31:0] a);
        return (a >= BASE) && (a <= BASE + 32'hF) && (a[1:0] == 2'b00);
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        int n = m_fifo.size();
        if (!in_window(a)) return 32'h0;
        case (a - BASE)
            32'h0: return m_portout;
            32'h4: return {24'b0, m_sync};
            32'h8: return (n > 0) ? {24'b0, m_fifo[0]} : 32'h0;
            32'hC: return 32'(n * 16 + (m_ovf ? 4 : 0) + ((n == DEPTH) ? 2 : 0) + ((n == 0) ? 1 : 0));
            default: return 32'h0;
        endcase
    endfunction

    // Effects at one clock edge: register write, then pop, then the port event.
    function automatic void m_commit(input logic w, input logic [31:0] a, input logic [31:0] d,
                                     input logic [7:0] pv);
        if (in_window(a) && w && (a - BASE) == 32'h0) m_portout = d;
        if (in_window(a) && w && (a - BASE) == 32'hC && d[2]) m_ovf = 1'b0;
        if (in_window(a) && !w && (a - BASE) == 32'h8 && m_fifo.size() > 0) void'(m_fifo.pop_front());
        if (pv != m_sync) begin
            if (m_fifo.size() < DEPTH) m_fifo.push_back(pv);
            else m_ovf = 1'b1;
        end
        m_sync = pv;
    endfunction

    always @(negedge clk) begin
        if (ack === 1'b1) begin
            if (exp_q.size() == 0) begin
                tot_cnt++;
                $display("FAIL unexpected_ack: ack seen with rdata 0x%08h, no response expected at %0t", rdata, $time);
            end else begin
                check("rdata", rdata, exp_q.pop_front());
            end
        end else begin
            check("rdata_idle_zero", rdata, 32'h0);
        end
    end

    task automatic post_checks();
        check("ack_one_cycle", 32'(ack), 32'h0);
        check("portout", PortOut, m_portout);
        check("irq", 32'(irq), 32'(m_fifo.size() != 0));
    endtask

    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d;
        exp_q.push_back(w ? 32'h0 : m_read(a));
        @(negedge clk);
        check("ack_latency", 32'(ack), 32'h1);
        req = 1'b0;
        @(negedge clk);
        m_commit(w, a, d, m_sync);
        post_checks();
    endtask

    task automatic port_change(input logic [7:0] v);
        @(negedge clk);
        PortIn = v;
        repeat (3) @(negedge clk);
        m_commit(1'b0, 32'h0, 32'h0, v);
        check("irq_evt", 32'(irq), 32'(m_fifo.size() != 0));
    endtask

    // Port change timed so its push lands on the edge that ends the ack cycle.
    task automatic txn_with_event(input logic w, input logic [31:0] a, input logic [31:0] d,
                                  input logic [7:0] v);
        @(negedge clk);
        PortIn = v;
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d;
        exp_q.push_back(w ? 32'h0 : m_read(a));
        @(negedge clk);
        check("ack_latency_evt", 32'(ack), 32'h1);
        req = 1'b0;
        @(negedge clk);
        m_commit(w, a, d, v);
        post_checks();
    endtask

    task automatic reset_abort();
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = BASE; wdata = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        reset = 1'b1;
        req = 1'b0;
        @(negedge clk);
        check("abort_no_ack", 32'(ack), 32'h0);
        @(negedge clk);
        check("abort_portout", PortOut, 32'h0);
        check("abort_irq", 32'(irq), 32'h0);
        reset = 1'b0;
        m_portout = '0;
        m_fifo.delete();
        m_ovf = 1'b0;
        m_sync = '0;
        txn(1'b0, BASE + 32'hC, 32'h0);
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 7))
            0, 1:    return BASE + 32'($urandom_range(0, 3) * 4);
            2, 3:    return BASE + 32'h8;
            4:       return BASE + 32'($urandom_range(0, 15));
            5:       return BASE + 32'h10 + 32'($urandom_range(0, 15) * 4);
            6:       return $urandom;
            default: return BASE + 32'hC;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish, expected completion before 1000000");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_ack", 32'(ack), 32'h0);
        check("reset_rdata", rdata, 32'h0);
        check("reset_portout", PortOut, 32'h0);
        check("reset_irq", 32'(irq), 32'h0);
        reset = 1'b0;

        txn(1'b1, BASE, 32'hDEAD_BEEF);
        txn(1'b0, BASE, 32'h0);

        port_change(8'h5A);
        txn(1'b0, BASE + 32'h4, 32'h0);
        txn(1'b0, BASE + 32'h8, 32'h0);

        for (int v = 1; v <= 5; v++) port_change(8'(v));
        txn(1'b0, BASE + 32'hC, 32'h0);
        for (int k = 0; k < 5; k++) txn(1'b0, BASE + 32'h8, 32'h0);

        txn(1'b1, BASE + 32'hC, 32'h4);
        txn(1'b0, BASE + 32'hC, 32'h0);
        for (int v = 6; v <= 9; v++) port_change(8'(v));
        txn_with_event(1'b1, BASE + 32'hC, 32'h4, 8'h0A);
        txn(1'b0, BASE + 32'hC, 32'h0);
        txn(1'b1, BASE + 32'hC, 32'h4);
        txn_with_event(1'b0, BASE + 32'h8, 32'h0, 8'h0B);
        txn(1'b0, BASE + 32'hC, 32'h0);
        for (int k = 0; k < 4; k++) txn(1'b0, BASE + 32'h8, 32'h0);
        txn_with_event(1'b0, BASE + 32'h8, 32'h0, 8'h0C);
        txn(1'b0, BASE + 32'hC, 32'h0);
        txn(1'b0, BASE + 32'h8, 32'h0);

        txn(1'b0, BASE + 32'h2, 32'h0);
        txn(1'b0, BASE + 32'h10, 32'h0);
        txn(1'b1, BASE + 32'h4, 32'hFFFF_FFFF);
        txn(1'b1, BASE + 32'h2, 32'h1234_5678);
        txn(1'b1, BASE + 32'h10, 32'h8765_4321);
        txn(1'b0, BASE, 32'h0);

        port_change(8'h00);
        reset_abort();

        for (int i = 0; i < 300; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 25) begin
                port_change(($urandom_range(0, 3) == 0) ? m_sync : 8'($urandom));
            end else if (r < 40) begin
                case ($urandom_range(0, 3))
                    0:       txn_with_event($urandom_range(0, 1) == 1, BASE, $urandom, 8'($urandom));
                    1:       txn_with_event(1'b0, BASE + 32'h8, 32'h0, 8'($urandom));
                    2:       txn_with_event(1'b0, BASE + 32'hC, 32'h0, 8'($urandom));
                    default: txn_with_event(1'b1, BASE + 32'hC, $urandom, 8'($urandom));
                endcase
            end else begin
                txn($urandom_range(0, 1) == 1, rand_addr(), $urandom);
            end
        end

        repeat (2) @(negedge clk);
        if (exp_q.size() != 0) begin
            tot_cnt++;
            $display("FAIL scoreboard_drain: %0d responses outstanding, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
